// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter with a small transmit FIFO
// Revision : 1.0  initial release
// ============================================================================
module mmio_uart_tx #(
    parameter logic [7:0] BASE_ADDR    = 8'hF0,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic       WE,
    input  logic [7:0] WD,
    output logic [7:0] RD,
    output logic       hit,
    output logic       tx,
    output logic       busy
);

    localparam int         c_PTR_W       = $clog2(FIFO_DEPTH);
    localparam int         c_CNT_W       = c_PTR_W + 1;
    localparam int         c_BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam logic [7:0] c_TXDATA_ADDR = BASE_ADDR;
    localparam logic [7:0] c_STATUS_ADDR = BASE_ADDR + 8'd1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL_CNT  = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;

    logic                w_empty;
    logic                w_full;
    logic                w_baud_end;
    logic                w_pop;
    logic                w_push_req;
    logic                w_push;
    logic                w_drop;
    logic                w_ovf_clr;
    logic [c_BAUD_W-1:0] w_baud_nxt;
    logic [2:0]          w_bit_idx_nxt;
    logic [7:0]          w_shift_nxt;
    logic                w_tx_nxt;
    logic [2:0]          w_cnt_disp;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL_CNT);
    assign w_baud_end = (r_baud == c_BAUD_LAST);

    assign w_push_req = WE && (A == c_TXDATA_ADDR);
    // A full FIFO still accepts a byte when the FSM pops in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = WE && (A == c_STATUS_ADDR) && WD[0];

    // ------------------------------------------------------------------ FIFO
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= WD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------- FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (!w_empty) w_state_nxt = c_START;
            c_START: if (w_baud_end) w_state_nxt = c_DATA;
            c_DATA:  if (w_baud_end && (r_bit_idx == 3'd7)) w_state_nxt = c_STOP;
            c_STOP:  if (w_baud_end) w_state_nxt = w_empty ? c_IDLE : c_START;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------ FSM output
    always_comb begin
        w_pop         = !w_empty && ((r_state == c_IDLE) ||
                                     ((r_state == c_STOP) && w_baud_end));
        w_baud_nxt    = '0;
        w_bit_idx_nxt = '0;
        w_shift_nxt   = r_shift;
        if ((r_state != c_IDLE) && !w_baud_end) begin
            w_baud_nxt = r_baud + c_BAUD_W'(1);
        end
        if (r_state == c_DATA) begin
            w_bit_idx_nxt = w_baud_end ? (r_bit_idx + 3'd1) : r_bit_idx;
        end
        if (w_pop) begin
            w_shift_nxt = r_mem[r_rd_ptr];
        end else if ((r_state == c_DATA) && w_baud_end) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
        end
        // tx is registered from the upcoming state so it changes on the same edge.
        case (w_state_nxt)
            c_START: w_tx_nxt = 1'b0;
            c_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // -------------------------------------------------------- bus read side
    generate
        if (c_CNT_W > 3) begin : g_cnt_sat
            assign w_cnt_disp = (r_count > c_CNT_W'(7)) ? 3'd7 : r_count[2:0];
        end else begin : g_cnt_ext
            assign w_cnt_disp = 3'(r_count);
        end
    endgenerate

    assign tx   = r_tx;
    assign busy = (r_state != c_IDLE) || !w_empty;
    assign hit  = (A[7:1] == BASE_ADDR[7:1]);
    assign RD   = (A == c_STATUS_ADDR) ?
                  {1'b0, w_cnt_disp, r_overflow, w_empty, w_full, busy} : 8'h00;

endmodule
`default_nettype wire
